// File: rtl/md_issue.sv
// Issue sequencer between the pipeline and a multi-cycle mult/div unit:
// hands one md-class op to the unit, tracks its busy window, returns mfhi/mflo data.
module md_issue #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int WD_SLACK    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        req_ready,
  input  logic        flush,
  output logic [3:0]  md_op,
  output logic [31:0] md_a,
  output logic [31:0] md_b,
  input  logic        md_busy,
  input  logic [31:0] md_hilo,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        stall,
  output logic        err
);

  localparam int         WD_LIMIT = DIV_CYCLES + WD_SLACK;
  localparam logic [4:0] WD_MAX   = 5'(WD_LIMIT);

  // The wait counter is 5 bits; a watchdog limit beyond that could never fire.
  if (WD_LIMIT > 31 || MULT_CYCLES < 1 || DIV_CYCLES < 1) begin : g_cfg_check
    $error("md_issue: cycle parameters out of range for the 5-bit wait counter");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t     state;
  logic [4:0] wcnt;
  logic [4:0] wcnt_inc;
  logic       squash;
  logic       accept;
  logic       op_ok;

  assign req_ready  = (state == IDLE) && !md_busy && !flush;
  assign accept     = req_valid && req_ready;
  assign op_ok      = (req_op >= 4'd1) && (req_op <= 4'd8);
  assign wcnt_inc   = (wcnt == 5'd31) ? wcnt : wcnt + 5'd1;
  assign stall      = (state != IDLE) || md_busy;
  // A flush seen in ISSUE is remembered; a flush during RESP kills the pulse directly.
  assign resp_valid = (state == RESP) && !squash && !flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      md_op     <= 4'd0;
      md_a      <= 32'd0;
      md_b      <= 32'd0;
      resp_data <= 32'd0;
      wcnt      <= 5'd0;
      err       <= 1'b0;
      squash    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept && op_ok) begin
            md_op  <= req_op;
            md_a   <= req_a;
            md_b   <= req_b;
            squash <= 1'b0;
            state  <= ISSUE;
          end
        end
        ISSUE: begin
          md_op <= 4'd0;
          if (md_op inside {[4'd1:4'd4]}) begin
            wcnt  <= 5'd0;
            state <= WAIT;
          end else if (md_op inside {[4'd5:4'd6]}) begin
            resp_data <= md_hilo;
            squash    <= flush;
            state     <= RESP;
          end else begin
            state <= IDLE;
          end
        end
        WAIT: begin
          if (!md_busy) begin
            state <= IDLE;
          end else begin
            wcnt <= wcnt_inc;
            if (wcnt_inc >= WD_MAX) begin
              err   <= 1'b1;
              state <= IDLE;
            end
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md_issue.sv
// Bench for md_issue: behavioural md unit, cycle-age scoreboard compared every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_md_issue;

  localparam int MULT_CYCLES = 5;
  localparam int DIV_CYCLES  = 10;
  localparam int WD_SLACK    = 2;
  localparam int WD_LIMIT    = DIV_CYCLES + WD_SLACK;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic [3:0]  req_op = 4'd0;
  logic [31:0] req_a = 32'd0;
  logic [31:0] req_b = 32'd0;
  logic        req_ready;
  logic        flush = 1'b0;
  logic [3:0]  md_op;
  logic [31:0] md_a;
  logic [31:0] md_b;
  logic        md_busy;
  logic [31:0] md_hilo;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        stall;
  logic        err;

  int n_pass = 0;
  int n_tot  = 0;
  logic chk_on = 1'b0;
  logic stuck  = 1'b0;

  always #5 clk = ~clk;

  md_issue #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES), .WD_SLACK(WD_SLACK)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op), .req_a(req_a),
    .req_b(req_b), .req_ready(req_ready), .flush(flush), .md_op(md_op), .md_a(md_a),
    .md_b(md_b), .md_busy(md_busy), .md_hilo(md_hilo), .resp_valid(resp_valid),
    .resp_data(resp_data), .stall(stall), .err(err)
  );

  function automatic logic [63:0] md_calc(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] r;
    case (op)
      4'd1: r = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
      4'd2: r = {32'd0, a} * {32'd0, b};
      4'd3: r = (b == 32'd0) ? {a, 32'hFFFF_FFFF} : {$signed(a) % $signed(b), $signed(a) / $signed(b)};
      4'd4: r = (b == 32'd0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      default: r = 64'd0;
    endcase
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b, want %b (t=%0t)", nm, act, exp, $time);
  endtask

  // Behavioural md unit: busy for N cycles counting the start cycle.
  logic [31:0] u_hi, u_lo;
  int          u_rem;
  always @(posedge clk) begin
    if (reset) begin
      u_hi <= 32'd0; u_lo <= 32'd0; u_rem <= 0;
    end else if (md_op inside {[4'd1:4'd4]}) begin
      {u_hi, u_lo} <= md_calc(md_op, md_a, md_b);
      u_rem <= (md_op <= 4'd2) ? MULT_CYCLES - 1 : DIV_CYCLES - 1;
    end else begin
      if (u_rem != 0) u_rem <= u_rem - 1;
      if (md_op == 4'd7) u_hi <= md_a;
      if (md_op == 4'd8) u_lo <= md_a;
    end
  end
  assign md_busy = (md_op inside {[4'd1:4'd4]}) || (u_rem != 0) || stuck;
  assign md_hilo = (md_op == 4'd5) ? u_hi : (md_op == 4'd6) ? u_lo : 32'd0;

  // Scoreboard: architectural HI/LO plus the age (cycles since accept) of the op in flight.
  logic        m_act, m_fl, m_err;
  int          m_k;
  logic [3:0]  m_op;
  logic [31:0] m_a, m_b, m_hi, m_lo, m_sel, m_rd;
  logic        m_ready, m_acc;
  assign m_ready = !m_act && !md_busy && !flush;
  assign m_acc   = req_valid && m_ready;

  always @(posedge clk) begin
    if (reset) begin
      m_act <= 1'b0; m_fl <= 1'b0; m_err <= 1'b0; m_k <= 0; m_op <= 4'd0;
      m_a <= 32'd0; m_b <= 32'd0; m_hi <= 32'd0; m_lo <= 32'd0; m_sel <= 32'd0; m_rd <= 32'd0;
    end else if (m_acc && req_op >= 4'd1 && req_op <= 4'd8) begin
      m_act <= 1'b1; m_k <= 1; m_op <= req_op; m_a <= req_a; m_b <= req_b; m_fl <= 1'b0;
      case (req_op)
        4'd1, 4'd2, 4'd3, 4'd4: {m_hi, m_lo} <= md_calc(req_op, req_a, req_b);
        4'd5: m_sel <= m_hi;
        4'd6: m_sel <= m_lo;
        4'd7: m_hi <= req_a;
        4'd8: m_lo <= req_a;
        default: ;
      endcase
    end else if (m_act) begin
      m_k <= m_k + 1;
      if (m_op == 4'd5 || m_op == 4'd6) begin
        if (m_k == 1) begin m_rd <= m_sel; m_fl <= flush; end
        else m_act <= 1'b0;
      end else if (m_op == 4'd7 || m_op == 4'd8) begin
        m_act <= 1'b0;
      end else if (m_k >= 2) begin
        if (!md_busy) m_act <= 1'b0;
        else if (m_k - 1 >= WD_LIMIT) begin m_err <= 1'b1; m_act <= 1'b0; end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk1("cyc_req_ready",  req_ready,  m_ready);
      chk ("cyc_md_op",      32'(md_op), (m_act && m_k == 1) ? 32'(m_op) : 32'd0);
      chk ("cyc_md_a",       md_a,       m_a);
      chk ("cyc_md_b",       md_b,       m_b);
      chk1("cyc_resp_valid", resp_valid, m_act && (m_op == 4'd5 || m_op == 4'd6) && m_k == 2 && !m_fl && !flush);
      chk ("cyc_resp_data",  resp_data,  m_rd);
      chk1("cyc_stall",      stall,      m_act || md_busy);
      chk1("cyc_err",        err,        m_err);
    end
  end

  // Present a request until the model says it is taken; n = cycle of acceptance (1 = first).
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, output int n);
    logic acc;
    acc = 1'b0; n = 0;
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    while (!acc && n < 200) begin
      @(negedge clk); acc = m_acc; n++;
      @(posedge clk); #1;
    end
    req_valid = 1'b0; req_op = 4'd0;
    if (!acc) chk1("accept_timeout", 1'b0, 1'b1);
  endtask

  task automatic wait_resp(output int lat, output logic [31:0] d);
    logic seen;
    seen = 1'b0; lat = 0; d = 32'd0;
    while (!seen && lat < 30) begin
      @(negedge clk); lat++;
      if (resp_valid) begin seen = 1'b1; d = resp_data; end
      @(posedge clk); #1;
    end
    if (!seen) chk1("resp_timeout", 1'b0, 1'b1);
  endtask

  initial begin
    int n, lat, sc, oc;
    logic [31:0] d;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0; chk_on = 1'b1;
    @(negedge clk);
    chk1("rst_ready", req_ready, 1'b1);
    chk ("rst_md_op", 32'(md_op), 32'd0);
    chk ("rst_resp_data", resp_data, 32'd0);
    chk1("rst_err", err, 1'b0);
    @(posedge clk); #1;

    // Signed mult -1 * 2, then read back both halves.
    issue(4'd1, 32'hFFFF_FFFF, 32'd2, n);
    sc = 0; oc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (stall) sc++;
      if (md_op == 4'd1) oc++;
      if (!stall) break;
    end
    @(posedge clk); #1;
    chk("mult_stall_cycles", sc, 6);
    chk("mult_md_op_cycles", oc, 1);
    issue(4'd6, 32'd0, 32'd0, n); wait_resp(lat, d);
    chk("mflo_data", d, 32'hFFFF_FFFE);
    chk("mflo_latency", lat, 2);
    issue(4'd5, 32'd0, 32'd0, n); wait_resp(lat, d);
    chk("mfhi_data", d, 32'hFFFF_FFFF);

    // divu 7/2 with mfhi presented back-to-back: held off until the unit is idle.
    issue(4'd4, 32'd7, 32'd2, n);
    issue(4'd5, 32'd0, 32'd0, n);
    chk("mfhi_after_divu_accept_cycle", n, 12);
    wait_resp(lat, d);
    chk("divu_remainder", d, 32'd1);

    // mthi then mfhi: two-cycle spacing, two-cycle latency.
    issue(4'd7, 32'h1234, 32'd0, n);
    issue(4'd5, 32'd0, 32'd0, n);
    chk("mthi_mfhi_spacing", n, 2);
    wait_resp(lat, d);
    chk("mthi_mfhi_data", d, 32'h0000_1234);
    chk("mthi_mfhi_latency", lat, 2);

    // mflo with flush in RESP: no pulse, data still lands (LO = 3 from divu).
    issue(4'd6, 32'd0, 32'd0, n);
    @(posedge clk); #1 flush = 1'b1;
    @(negedge clk);
    chk1("flush_resp_valid", resp_valid, 1'b0);
    chk ("flush_resp_data", resp_data, 32'd3);
    @(posedge clk); #1 flush = 1'b0;
    issue(4'd8, 32'hBEEF, 32'd0, n);
    chk("after_flush_accept_cycle", n, 1);
    issue(4'd6, 32'd0, 32'd0, n); wait_resp(lat, d);
    chk("mtlo_mflo_data", d, 32'h0000_BEEF);

    // mfhi with flush in ISSUE.
    issue(4'd5, 32'd0, 32'd0, n);
    flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    chk1("flush_issue_resp_valid", resp_valid, 1'b0);
    chk ("flush_issue_resp_data", resp_data, 32'h0000_1234);
    @(posedge clk); #1;

    // Stuck-busy div: watchdog fires after 12 WAIT cycles and stays set.
    issue(4'd3, 32'd100, 32'd7, n);
    stuck = 1'b1;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); n++;
      if (err) break;
    end
    chk ("wd_err_cycle", n, 14);
    chk1("wd_stall_held", stall, 1'b1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk1("wd_err_sticky", err, 1'b1);
    chk1("wd_ready_low", req_ready, 1'b0);
    @(posedge clk); #1 stuck = 1'b0; reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk1("wd_err_cleared", err, 1'b0);
    @(posedge clk); #1;

    // Reset mid-WAIT, then a reserved opcode is swallowed.
    issue(4'd2, 32'd3, 32'd4, n);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk ("rstw_md_op", 32'(md_op), 32'd0);
    chk ("rstw_md_a", md_a, 32'd0);
    chk ("rstw_md_b", md_b, 32'd0);
    chk1("rstw_resp_valid", resp_valid, 1'b0);
    chk ("rstw_resp_data", resp_data, 32'd0);
    chk1("rstw_stall", stall, 1'b0);
    chk1("rstw_ready", req_ready, 1'b1);
    @(posedge clk); #1;
    issue(4'd12, 32'd5, 32'd6, n);
    chk("op12_accept_cycle", n, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk ("op12_md_op", 32'(md_op), 32'd0);
      chk1("op12_stall", stall, 1'b0);
    end
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, want finished");
    $fatal(1);
  end

endmodule
